click_decoder: RTL and testbench

- Consumes the conditioned button path: the single-cycle rising-edge pulse and the debounced, synchronised level, both on the divided clock domain.
- Classifies each press as a single click, a double click or a long press.
- Emits one-cycle event strobes and keeps a running count of accepted presses.
- Sits directly downstream of the edge-detect stage and feeds the mode/display control logic.

---
 rtl/click_pkg.sv | 31 +++
 rtl/click_decoder_tick_timer.sv | 39 +++
 rtl/click_decoder.sv | 125 ++++++++++++
 tb/tb_click_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/click_pkg.sv
// click_pkg
// Shared definitions for the button click decoder and its neighbours.
//   - FSM state encoding (2-bit): IDLE=0, HOLD1=1, GAP=2, WAIT_REL=3
//   - Default LONG_TICKS / DBL_WINDOW values, also reused by the
//     mode/display control logic.
//   - timer_width(): width of the shared interval timer.
package click_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_HOLD1    = 2'd1;
   localparam logic [1:0] ST_GAP      = 2'd2;
   localparam logic [1:0] ST_WAIT_REL = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      HOLD1    = ST_HOLD1,
      GAP      = ST_GAP,
      WAIT_REL = ST_WAIT_REL
   } state_t;

   localparam int LONG_TICKS_DEF = 8;
   localparam int DBL_WINDOW_DEF = 5;

   // clog2(max(long_ticks, dbl_window)) + 1
   function automatic int timer_width(input int long_ticks, input int dbl_window);
      int m;
      m = (long_ticks > dbl_window) ? long_ticks : dbl_window;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/click_decoder_tick_timer.sv
// tick_timer
// Interval timer shared by the HOLD1 and GAP phases of the click decoder.
// Counts tick_en strobes from zero; done is flagged combinationally when a
// tick arrives while count == term-1. The count saturates at that value, so
// it never exceeds the terminal value.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         synchronous clear to zero (has priority over counting)
//   tick_en     timebase strobe; the only thing that advances the count
//   term        terminal value (>= 2)
//   count       current count
//   done        tick_en arrived with count == term-1
module tick_timer #(
   parameter int TW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          tick_en,
   input  logic [TW-1:0] term,
   output logic [TW-1:0] count,
   output logic          done
);

   assign done = tick_en && (count == term - TW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         // NOTE: sequential state always uses non-blocking assignment so every
         // register samples pre-edge values regardless of statement order.
         count <= '0;
      end else if (tick_en && !done) begin
         count <= count + TW'(1);
      end
   end

endmodule

// File: rtl/click_decoder.sv
// click_decoder
// Classifies button presses as single click, double click or long press.
// Inputs come from the edge-detect stage: a one-cycle rising-edge pulse and
// the debounced level, both on the stage clock.
// Ports:
//   clk, rst_n  stage clock, asynchronous active-low reset
//   tick_en     one-cycle timebase strobe (nominally 1 ms)
//   pulse_in    one-cycle rising-edge pulse
//   level_in    debounced, synchronised button level
//   single_o    one-cycle strobe: single click
//   double_o    one-cycle strobe: double click
//   long_o      one-cycle strobe: long press
//   busy_o      registered (state != IDLE)
//   click_cnt   count of accepted presses, wraps silently
module click_decoder
   import click_pkg::*;
#(
   parameter int LONG_TICKS = LONG_TICKS_DEF,
   parameter int DBL_WINDOW = DBL_WINDOW_DEF,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_en,
   input  logic             pulse_in,
   input  logic             level_in,
   output logic             single_o,
   output logic             double_o,
   output logic             long_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] click_cnt
);

   localparam int TW = timer_width(LONG_TICKS, DBL_WINDOW);

   state_t          state, next_state;
   logic            timer_clr;
   logic [TW-1:0]   timer_term;
   logic [TW-1:0]   timer_cnt;
   logic            timer_done;
   logic            single_nx, double_nx, long_nx, cnt_inc;

   // One timer serves both phases; only one interval is ever running.
   tick_timer #(.TW(TW)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (timer_clr),
      .tick_en (tick_en),
      .term    (timer_term),
      .count   (timer_cnt),
      .done    (timer_done)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a signal unassigned (latch).
      next_state = state;
      single_nx  = 1'b0;
      double_nx  = 1'b0;
      long_nx    = 1'b0;
      cnt_inc    = 1'b0;
      timer_clr  = 1'b1;
      timer_term = TW'(LONG_TICKS);

      case (state)
         IDLE: begin
            if (pulse_in) begin
               next_state = HOLD1;
               cnt_inc    = 1'b1;
            end
         end
         HOLD1: begin
            // Release beats the terminal tick: the press becomes a click.
            if (!level_in) begin
               next_state = GAP;
            end else begin
               timer_clr = 1'b0;
               if (timer_done) begin
                  long_nx    = 1'b1;
                  next_state = WAIT_REL;
               end
            end
         end
         GAP: begin
            timer_term = TW'(DBL_WINDOW);
            // A second press beats the window timeout.
            if (pulse_in) begin
               double_nx  = 1'b1;
               cnt_inc    = 1'b1;
               next_state = WAIT_REL;
            end else begin
               timer_clr = 1'b0;
               if (timer_done) begin
                  single_nx  = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         WAIT_REL: begin
            if (!level_in) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         single_o  <= 1'b0;
         double_o  <= 1'b0;
         long_o    <= 1'b0;
         busy_o    <= 1'b0;
         click_cnt <= '0;
      end else begin
         state    <= next_state;
         single_o <= single_nx;
         double_o <= double_nx;
         long_o   <= long_nx;
         // Decoded from next_state so busy_o lines up with the new state.
         busy_o   <= (next_state != IDLE);
         if (cnt_inc) click_cnt <= click_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_click_decoder.sv
// tb_click_decoder
// Self-checking bench for click_decoder (LONG_TICKS=4, DBL_WINDOW=3, CNT_W=2).
// The reference model tracks each press in terms of elapsed tick counts
// since the press/release began and decides events from those differences.
module tb_click_decoder;

   localparam int LT = 4;
   localparam int DW = 3;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tick_en = 1'b0;
   logic          pulse_in = 1'b0;
   logic          level_in = 1'b0;
   logic          single_o, double_o, long_o, busy_o;
   logic [CW-1:0] click_cnt;

   click_decoder #(.LONG_TICKS(LT), .DBL_WINDOW(DW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_en   (tick_en),
      .pulse_in  (pulse_in),
      .level_in  (level_in),
      .single_o  (single_o),
      .double_o  (double_o),
      .long_o    (long_o),
      .busy_o    (busy_o),
      .click_cnt (click_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", tag, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // A press is either being held, in its release gap, or waiting for the
   // button to come up after a decided event. Nothing set = idle.
   bit held, gapping, waiting;
   int tick_total;      // all ticks seen since reset
   int mark;            // tick_total at the start of the current interval
   int m_cnt;
   bit e_single, e_double, e_long;

   int  tick_mode = 0;  // 0 every cycle, 1 every 4th cycle, 2 random
   int  cyc = 0;
   bit  prev_level = 0;

   task automatic model_clear();
      held = 0; gapping = 0; waiting = 0;
      tick_total = 0; mark = 0; m_cnt = 0;
      e_single = 0; e_double = 0; e_long = 0;
   endtask

   task automatic model_step(input bit p, input bit l, input bit t);
      e_single = 0; e_double = 0; e_long = 0;
      if (!held && !gapping && !waiting) begin
         if (p) begin
            held  = 1;
            mark  = tick_total + int'(t);
            m_cnt = (m_cnt + 1) % (1 << CW);
         end
      end else if (held) begin
         if (!l) begin
            held = 0; gapping = 1;
            mark = tick_total + int'(t);
         end else if (t && (tick_total + 1 - mark == LT)) begin
            e_long = 1; held = 0; waiting = 1;
         end
      end else if (gapping) begin
         if (p) begin
            e_double = 1; gapping = 0; waiting = 1;
            m_cnt = (m_cnt + 1) % (1 << CW);
         end else if (t && (tick_total + 1 - mark == DW)) begin
            e_single = 1; gapping = 0;
         end
      end else begin
         if (!l) waiting = 0;
      end
      tick_total += int'(t);
   endtask

   task automatic compare_all(input string where);
      check({where, ".single"}, 32'(single_o), 32'(e_single));
      check({where, ".double"}, 32'(double_o), 32'(e_double));
      check({where, ".long"},   32'(long_o),   32'(e_long));
      check({where, ".busy"},   32'(busy_o),   32'(held | gapping | waiting));
      check({where, ".cnt"},    32'(click_cnt), 32'(m_cnt));
   endtask

   // One clock: compare what the previous edge produced, then drive the
   // inputs for the next edge and advance the model with those same inputs.
   task automatic step(input bit lvl, input bit extra_pulse);
      bit t;
      @(negedge clk);
      compare_all("cyc");
      case (tick_mode)
         0:       t = 1'b1;
         1:       t = (cyc % 4 == 0);
         default: t = ($urandom_range(0, 2) == 0);
      endcase
      level_in   = lvl;
      pulse_in   = (lvl & ~prev_level) | extra_pulse;
      tick_en    = t;
      prev_level = lvl;
      cyc++;
      model_step(pulse_in, level_in, tick_en);
   endtask

   task automatic press(input int hi, input int lo);
      for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
   endtask

   task automatic do_reset(input int ncyc);
      @(negedge clk);
      rst_n = 1'b0;
      level_in = 1'b0; pulse_in = 1'b0; tick_en = 1'b0; prev_level = 1'b0;
      #1;
      model_clear();
      compare_all("rst");
      repeat (ncyc) @(negedge clk);
      compare_all("rst_hold");
      rst_n = 1'b1;
   endtask

   initial begin
      model_clear();
      do_reset(2);

      // Single click, double click, long press with stray pulses mid-hold.
      tick_mode = 0;
      press(2, 8);
      press(2, 1);
      press(2, 8);
      for (int i = 0; i < 10; i++) step(1'b1, (i == 6));
      press(0, 4);

      // Tie: second pulse lands on GAP's terminal tick.
      press(2, 3);
      press(2, 8);
      // Tie: release lands on HOLD1's terminal tick.
      press(4, 8);

      // Wrap of the 2-bit counter across five single clicks.
      for (int k = 0; k < 5; k++) press(2, 6);

      // Reset during GAP, then a normal click.
      press(2, 2);
      do_reset(2);
      press(0, 3);
      press(2, 8);

      // Sparse ticks: every 4th cycle.
      tick_mode = 1;
      press(2, 20);
      press(2, 4);
      press(2, 20);
      press(20, 4);

      // Randomised button activity with random ticks.
      tick_mode = 2;
      for (int s = 0; s < 300; s++) begin
         int dur;
         bit lvl;
         dur = $urandom_range(1, 12);
         lvl = s[0];
         for (int i = 0; i < dur; i++)
            step(lvl, ($urandom_range(0, 19) == 0));
         if ($urandom_range(0, 59) == 0) do_reset(1);
      end
      press(0, 30);
      @(negedge clk);
      compare_all("end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
